// File: rtl/tx_axis_frame_arbiter_if.sv
// AXI4-Stream bundle with N_LANES parallel 64-bit lanes.
// Lane k occupies tdata[64k+:64] and tkeep[8k+:8].
interface tx_axis_frame_arbiter_if #(
  parameter int N_LANES = 1
);
  logic [N_LANES*64-1:0] tdata;
  logic [N_LANES*8-1:0]  tkeep;
  logic [N_LANES-1:0]    tvalid;
  logic [N_LANES-1:0]    tready;
  logic [N_LANES-1:0]    tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_axis_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one Tx MAC AXIS input from NUM_SRC sources.
// An owner keeps the grant until tlast; stalled-out or oversize frames are flushed and reported.
module tx_axis_frame_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int MAX_FRAME_BEATS = 192
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  tx_axis_frame_arbiter_if.slave     s_axis,
  tx_axis_frame_arbiter_if.master    m_axis,
  output logic [NUM_SRC-1:0]         o_grant,
  output logic                       o_abort,
  output logic [$clog2(NUM_SRC)-1:0] o_abort_src
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_FRAME_BEATS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_SRC - 1);
  localparam logic [CW-1:0] MAX_BEATS = CW'(MAX_FRAME_BEATS);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t        state_reg;
  logic [IW-1:0] owner_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [CW-1:0] beat_cnt_reg;

  logic [63:0]        src_data [NUM_SRC];
  logic [7:0]         src_keep [NUM_SRC];
  logic [NUM_SRC-1:0] src_ready;

  logic          sel_valid;
  logic          sel_last;
  logic          accept;
  logic [IW-1:0] next_ptr;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] pick;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_data[gi]  = s_axis.tdata[64*gi +: 64];
      assign src_keep[gi]  = s_axis.tkeep[8*gi +: 8];
      // Owner sees the MAC's ready while streaming; during FLUSH it is drained unconditionally.
      assign src_ready[gi] = (owner_reg == IW'(gi)) &&
                             (((state_reg == ACTIVE) && m_axis.tready[0]) || (state_reg == FLUSH));
    end
  endgenerate

  assign s_axis.tready = src_ready;

  assign sel_valid       = s_axis.tvalid[owner_reg];
  assign sel_last        = s_axis.tlast[owner_reg];
  assign m_axis.tdata    = src_data[owner_reg];
  assign m_axis.tkeep    = src_keep[owner_reg];
  assign m_axis.tlast[0] = sel_last;
  assign m_axis.tvalid[0] = (state_reg == ACTIVE) && sel_valid;

  assign accept   = m_axis.tvalid[0] && m_axis.tready[0];
  assign next_ptr = (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
  assign cnt_inc  = (beat_cnt_reg == MAX_BEATS) ? beat_cnt_reg : beat_cnt_reg + 1'b1;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx_int;
    logic found;
    logic [IW-1:0] idx;
    pick    = rr_ptr_reg;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx_int = int'(rr_ptr_reg) + i;
      if (idx_int >= NUM_SRC) idx_int = idx_int - NUM_SRC;
      idx = IW'(idx_int);
      if (!found && s_axis.tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
      o_grant      <= '0;
      o_abort      <= 1'b0;
      o_abort_src  <= '0;
    end else begin
      o_abort <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|s_axis.tvalid) begin
            owner_reg    <= pick;
            o_grant      <= NUM_SRC'(1) << pick;
            beat_cnt_reg <= '0;
            state_reg    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            beat_cnt_reg <= cnt_inc;
            if (sel_last) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= next_ptr;
              o_grant    <= '0;
            end else if (cnt_inc == MAX_BEATS) begin
              state_reg   <= FLUSH;
              o_abort     <= 1'b1;
              o_abort_src <= owner_reg;
            end
          end else if (!sel_valid) begin
            if (beat_cnt_reg == '0) begin
              // Request withdrawn before any beat moved: no frame to abort.
              state_reg <= IDLE;
              o_grant   <= '0;
            end else if (m_axis.tready[0]) begin
              state_reg   <= FLUSH;
              o_abort     <= 1'b1;
              o_abort_src <= owner_reg;
            end
          end
        end
        FLUSH: begin
          if (sel_valid && sel_last) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= next_ptr;
            o_grant    <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// Directed bench for tx_axis_frame_arbiter: 4 sources, MAX_FRAME_BEATS=8.
// A negedge monitor logs every beat the MAC accepts; each scenario task checks inline.
module tb_tx_axis_frame_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] o_grant;
  logic       o_abort;
  logic [1:0] o_abort_src;

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int abort_cnt = 0;

  always #5 i_clk = ~i_clk;

  tx_axis_frame_arbiter_if #(.N_LANES(4)) s_if ();
  tx_axis_frame_arbiter_if #(.N_LANES(1)) m_if ();

  tx_axis_frame_arbiter #(.NUM_SRC(4), .MAX_FRAME_BEATS(8)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .o_grant     (o_grant),
    .o_abort     (o_abort),
    .o_abort_src (o_abort_src)
  );

  typedef struct packed {
    logic [3:0]  grant;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t mon_q[$];

  always @(negedge i_clk) begin
    if (m_if.tvalid[0] === 1'b1 && m_if.tready[0] === 1'b1)
      mon_q.push_back('{grant: o_grant, data: m_if.tdata, keep: m_if.tkeep, last: m_if.tlast[0]});
    if (o_abort === 1'b1) abort_cnt++;
  end

  function automatic logic [63:0] mk(input int k, input int f, input int b);
    return {8'hA0 | 8'(k), 8'(f), 8'(b), 40'h00_1234_5678};
  endfunction

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic v, input logic [63:0] d, input logic [7:0] kp, input logic l);
    s_if.tvalid[k]        = v;
    s_if.tdata[64*k +: 64] = d;
    s_if.tkeep[8*k +: 8]   = kp;
    s_if.tlast[k]         = l;
  endtask

  task automatic clear_all();
    s_if.tvalid = '0;
    s_if.tlast  = '0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
  endtask

  // Presents one beat on source k and returns one cycle after it has been taken.
  task automatic push_beat(input int k, input logic [63:0] d, input logic [7:0] kp, input logic l, output bit ok);
    set_src(k, 1'b1, d, kp, l);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (s_if.tready[k] === 1'b1) begin
        ok = 1'b1;
        cyc();
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (o_grant !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    bit ok;
    i_reset = 1'b1;
    m_if.tready = 1'b1;
    s_if.tvalid = 4'hF;
    cyc();
    cyc();
    vec_cnt++; if (o_grant !== 4'b0000) begin err_cnt++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    vec_cnt++; if (o_abort !== 1'b0) begin err_cnt++; $display("FAIL reset_abort: got %b want 0", o_abort); end
    vec_cnt++; if (o_abort_src !== 2'd0) begin err_cnt++; $display("FAIL reset_abort_src: got %0d want 0", o_abort_src); end
    vec_cnt++; if (m_if.tvalid[0] !== 1'b0) begin err_cnt++; $display("FAIL reset_m_tvalid: got %b want 0", m_if.tvalid[0]); end
    vec_cnt++; if (s_if.tready !== 4'b0000) begin err_cnt++; $display("FAIL reset_s_tready: got %b want 0000", s_if.tready); end
    clear_all();
    i_reset = 1'b0;
    cyc();
    ok = 1'b1;
    $display("reset: checked idle outputs");
  endtask

  task automatic test_single_source();
    bit ok;
    logic [63:0] d [3];
    logic [7:0]  kp [3];
    mon_q.delete();
    for (int i = 0; i < 3; i++) begin
      d[i]  = mk(1, 1, i);
      kp[i] = (i == 2) ? 8'h0F : 8'hFF;
    end
    set_src(1, 1'b1, d[0], kp[0], 1'b0);
    #1;
    vec_cnt++; if (o_grant !== 4'b0000) begin err_cnt++; $display("FAIL t1_grant_latency: got %b want 0000", o_grant); end
    vec_cnt++; if (m_if.tvalid[0] !== 1'b0) begin err_cnt++; $display("FAIL t1_idle_tvalid: got %b want 0", m_if.tvalid[0]); end
    cyc();
    vec_cnt++; if (o_grant !== 4'b0010) begin err_cnt++; $display("FAIL t1_grant: got %b want 0010", o_grant); end
    for (int i = 0; i < 3; i++) begin
      push_beat(1, d[i], kp[i], (i == 2), ok);
      vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL t1_beat_timeout: beat %0d never accepted", i); end
    end
    set_src(1, 1'b0, '0, '0, 1'b0);
    #1;
    vec_cnt++; if (o_grant !== 4'b0000) begin err_cnt++; $display("FAIL t1_idle_after: got %b want 0000", o_grant); end
    vec_cnt++; if (mon_q.size() != 3) begin err_cnt++; $display("FAIL t1_beat_count: got %0d want 3", mon_q.size()); end
    for (int i = 0; i < 3 && i < mon_q.size(); i++) begin
      vec_cnt++;
      if (mon_q[i].data !== d[i] || mon_q[i].keep !== kp[i] || mon_q[i].last !== (i == 2) || mon_q[i].grant !== 4'b0010) begin
        err_cnt++;
        $display("FAIL t1_beat%0d: got d=%h k=%h l=%b g=%b want d=%h k=%h l=%b g=0010",
                 i, mon_q[i].data, mon_q[i].keep, mon_q[i].last, mon_q[i].grant, d[i], kp[i], (i == 2));
      end
    end
    // rr_ptr is now 2: src2 must beat src0 on a tie.
    set_src(0, 1'b1, mk(0, 1, 0), 8'hFF, 1'b1);
    set_src(2, 1'b1, mk(2, 1, 0), 8'hFF, 1'b1);
    cyc();
    vec_cnt++; if (o_grant !== 4'b0100) begin err_cnt++; $display("FAIL t1_rr_ptr2: got %b want 0100", o_grant); end
    push_beat(2, mk(2, 1, 0), 8'hFF, 1'b1, ok);
    set_src(2, 1'b0, '0, '0, 1'b0);
    wait_grant(ok);
    vec_cnt++; if (o_grant !== 4'b0001) begin err_cnt++; $display("FAIL t1_next_src0: got %b want 0001", o_grant); end
    push_beat(0, mk(0, 1, 0), 8'hFF, 1'b1, ok);
    set_src(0, 1'b0, '0, '0, 1'b0);
    $display("t1: src1 3-beat frame, then src2, src0");
  endtask

  task automatic test_round_robin();
    bit ok;
    int order [5] = '{0, 1, 2, 3, 0};
    int k, f;
    logic [3:0] exp_g;
    i_reset = 1'b1;
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, mk(s, 0, 0), 8'hFF, 1'b0);
    cyc();
    i_reset = 1'b0;
    mon_q.delete();
    for (int i = 0; i < 5; i++) begin
      k = order[i];
      f = (i == 4) ? 1 : 0;
      exp_g = 4'b0001 << k;
      wait_grant(ok);
      vec_cnt++; if (o_grant !== exp_g) begin err_cnt++; $display("FAIL t2_grant%0d: got %b want %b", i, o_grant, exp_g); end
      push_beat(k, mk(k, f, 0), 8'hFF, 1'b0, ok);
      push_beat(k, mk(k, f, 1), 8'hFF, 1'b1, ok);
      if (i == 0) set_src(0, 1'b1, mk(0, 1, 0), 8'hFF, 1'b0);
      else        set_src(k, 1'b0, '0, '0, 1'b0);
      $display("t2: frame %0d from src%0d", i, k);
    end
    vec_cnt++; if (mon_q.size() != 10) begin err_cnt++; $display("FAIL t2_beat_count: got %0d want 10", mon_q.size()); end
    for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
      k = order[i / 2];
      f = (i / 2 == 4) ? 1 : 0;
      exp_g = 4'b0001 << k;
      vec_cnt++;
      if (mon_q[i].data !== mk(k, f, i % 2) || mon_q[i].grant !== exp_g || mon_q[i].last !== (i % 2 == 1)) begin
        err_cnt++;
        $display("FAIL t2_beat%0d: got d=%h g=%b l=%b want d=%h g=%b l=%b",
                 i, mon_q[i].data, mon_q[i].grant, mon_q[i].last, mk(k, f, i % 2), exp_g, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int ab0;
    mon_q.delete();
    ab0 = abort_cnt;
    set_src(2, 1'b1, mk(2, 2, 0), 8'hFF, 1'b0);
    wait_grant(ok);
    vec_cnt++; if (o_grant !== 4'b0100) begin err_cnt++; $display("FAIL t3_grant: got %b want 0100", o_grant); end
    push_beat(2, mk(2, 2, 0), 8'hFF, 1'b0, ok);
    set_src(2, 1'b1, mk(2, 2, 1), 8'h3C, 1'b0);
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vec_cnt++;
      if (m_if.tvalid[0] !== 1'b1 || m_if.tdata !== mk(2, 2, 1) || m_if.tkeep !== 8'h3C ||
          m_if.tlast[0] !== 1'b0 || s_if.tready[2] !== 1'b0 || o_abort !== 1'b0) begin
        err_cnt++;
        $display("FAIL t3_stall%0d: got v=%b d=%h k=%h l=%b rdy2=%b ab=%b want v=1 d=%h k=3c l=0 rdy2=0 ab=0",
                 i, m_if.tvalid[0], m_if.tdata, m_if.tkeep, m_if.tlast[0], s_if.tready[2], o_abort, mk(2, 2, 1));
      end
      cyc();
    end
    m_if.tready = 1'b1;
    push_beat(2, mk(2, 2, 1), 8'h3C, 1'b0, ok);
    push_beat(2, mk(2, 2, 2), 8'hFF, 1'b1, ok);
    set_src(2, 1'b0, '0, '0, 1'b0);
    vec_cnt++; if (mon_q.size() != 3) begin err_cnt++; $display("FAIL t3_beat_count: got %0d want 3", mon_q.size()); end
    vec_cnt++;
    if (mon_q.size() > 1 && (mon_q[1].data !== mk(2, 2, 1) || mon_q[1].keep !== 8'h3C)) begin
      err_cnt++;
      $display("FAIL t3_stalled_beat: got d=%h k=%h want d=%h k=3c", mon_q[1].data, mon_q[1].keep, mk(2, 2, 1));
    end
    vec_cnt++; if (abort_cnt != ab0) begin err_cnt++; $display("FAIL t3_no_abort: got %0d aborts want 0", abort_cnt - ab0); end
    $display("t3: src2 frame with 5-cycle stall");
  endtask

  task automatic test_drop_abort();
    bit ok;
    int ab0;
    mon_q.delete();
    ab0 = abort_cnt;
    set_src(0, 1'b1, mk(0, 4, 0), 8'hFF, 1'b0);
    set_src(1, 1'b1, mk(1, 4, 0), 8'hFF, 1'b1);
    wait_grant(ok);
    vec_cnt++; if (o_grant !== 4'b0001) begin err_cnt++; $display("FAIL t4_grant: got %b want 0001", o_grant); end
    for (int b = 0; b < 4; b++) push_beat(0, mk(0, 4, b), 8'hFF, 1'b0, ok);
    set_src(0, 1'b0, mk(0, 4, 4), 8'hFF, 1'b0);
    #1;
    vec_cnt++; if (m_if.tvalid[0] !== 1'b0) begin err_cnt++; $display("FAIL t4_drop_tvalid: got %b want 0", m_if.tvalid[0]); end
    cyc();
    vec_cnt++; if (o_abort !== 1'b1) begin err_cnt++; $display("FAIL t4_abort_pulse: got %b want 1", o_abort); end
    vec_cnt++; if (o_abort_src !== 2'd0) begin err_cnt++; $display("FAIL t4_abort_src: got %0d want 0", o_abort_src); end
    vec_cnt++; if (s_if.tready !== 4'b0001) begin err_cnt++; $display("FAIL t4_flush_ready: got %b want 0001", s_if.tready); end
    vec_cnt++; if (o_grant !== 4'b0001) begin err_cnt++; $display("FAIL t4_flush_grant: got %b want 0001", o_grant); end
    cyc();
    vec_cnt++; if (o_abort !== 1'b0) begin err_cnt++; $display("FAIL t4_abort_width: got %b want 0", o_abort); end
    push_beat(0, 64'hDEAD_0000_0000_0001, 8'hFF, 1'b0, ok);
    push_beat(0, 64'hDEAD_0000_0000_0002, 8'hFF, 1'b1, ok);
    set_src(0, 1'b0, '0, '0, 1'b0);
    vec_cnt++; if (mon_q.size() != 4) begin err_cnt++; $display("FAIL t4_flushed: got %0d beats want 4", mon_q.size()); end
    vec_cnt++; if (abort_cnt != ab0 + 1) begin err_cnt++; $display("FAIL t4_abort_count: got %0d want 1", abort_cnt - ab0); end
    wait_grant(ok);
    vec_cnt++; if (o_grant !== 4'b0010) begin err_cnt++; $display("FAIL t4_next_grant: got %b want 0010", o_grant); end
    push_beat(1, mk(1, 4, 0), 8'hFF, 1'b1, ok);
    set_src(1, 1'b0, '0, '0, 1'b0);
    $display("t4: src0 dropped mid-frame, flushed; src1 served");
  endtask

  task automatic test_max_beats();
    bit ok;
    mon_q.delete();
    set_src(3, 1'b1, mk(3, 5, 1), 8'hFF, 1'b0);
    wait_grant(ok);
    vec_cnt++; if (o_grant !== 4'b1000) begin err_cnt++; $display("FAIL t5_grant: got %b want 1000", o_grant); end
    for (int b = 1; b <= 12; b++) begin
      push_beat(3, mk(3, 5, b), 8'hFF, (b == 12), ok);
      vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL t5_beat_timeout: beat %0d never taken", b); end
      if (b == 8) begin
        vec_cnt++; if (o_abort !== 1'b1) begin err_cnt++; $display("FAIL t5_abort_pulse: got %b want 1", o_abort); end
        vec_cnt++; if (o_abort_src !== 2'd3) begin err_cnt++; $display("FAIL t5_abort_src: got %0d want 3", o_abort_src); end
        vec_cnt++; if (m_if.tvalid[0] !== 1'b0) begin err_cnt++; $display("FAIL t5_flush_tvalid: got %b want 0", m_if.tvalid[0]); end
      end
    end
    set_src(3, 1'b0, '0, '0, 1'b0);
    vec_cnt++; if (o_grant !== 4'b0000) begin err_cnt++; $display("FAIL t5_idle: got %b want 0000", o_grant); end
    vec_cnt++; if (mon_q.size() != 8) begin err_cnt++; $display("FAIL t5_beat_count: got %0d want 8", mon_q.size()); end
    vec_cnt++;
    if (mon_q.size() == 8 && (mon_q[7].data !== mk(3, 5, 8) || mon_q[7].last !== 1'b0)) begin
      err_cnt++;
      $display("FAIL t5_last_beat: got d=%h l=%b want d=%h l=0", mon_q[7].data, mon_q[7].last, mk(3, 5, 8));
    end
    $display("t5: src3 12-beat frame cut at 8");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    set_src(1, 1'b1, mk(1, 6, 0), 8'hFF, 1'b0);
    wait_grant(ok);
    vec_cnt++; if (o_grant !== 4'b0010) begin err_cnt++; $display("FAIL t6_grant: got %b want 0010", o_grant); end
    push_beat(1, mk(1, 6, 0), 8'hFF, 1'b0, ok);
    set_src(1, 1'b1, mk(1, 6, 1), 8'hFF, 1'b0);
    #2;
    i_reset = 1'b1;
    #1;
    vec_cnt++; if (o_grant !== 4'b0000) begin err_cnt++; $display("FAIL t6_async_grant: got %b want 0000", o_grant); end
    vec_cnt++; if (m_if.tvalid[0] !== 1'b0) begin err_cnt++; $display("FAIL t6_async_tvalid: got %b want 0", m_if.tvalid[0]); end
    vec_cnt++; if (s_if.tready !== 4'b0000) begin err_cnt++; $display("FAIL t6_async_tready: got %b want 0000", s_if.tready); end
    set_src(0, 1'b1, mk(0, 6, 0), 8'hFF, 1'b1);
    cyc();
    cyc();
    i_reset = 1'b0;
    cyc();
    vec_cnt++; if (o_grant !== 4'b0001) begin err_cnt++; $display("FAIL t6_tie_after_reset: got %b want 0001", o_grant); end
    clear_all();
    $display("t6: reset during src1 frame, src0 wins tie");
  endtask

  initial begin
    i_reset = 1'b1;
    m_if.tready = 1'b1;
    clear_all();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_drop_abort();
    test_max_beats();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
